// File: rtl/camera_frame_sequencer_if.sv
// camera_frame_sequencer_if: camera/consumer handshake and writer bus of the frame sequencer
interface camera_frame_sequencer_if;
    logic        enable;
    logic        sof;
    logic        pixel_valid;
    logic        rd_acquire;
    logic        rd_release;
    logic        wr_en;
    logic [25:0] wr_addr;
    logic [1:0]  rd_buf;
    logic        rd_buf_valid;
    logic        rd_ack;
    logic        frame_done;
    logic        frame_error;
    logic        capturing;
    logic [15:0] frame_count;
    logic [7:0]  error_count;
    modport master (
        output enable, sof, pixel_valid, rd_acquire, rd_release,
        input  wr_en, wr_addr, rd_buf, rd_buf_valid, rd_ack,
               frame_done, frame_error, capturing, frame_count, error_count
    );
    modport slave (
        input  enable, sof, pixel_valid, rd_acquire, rd_release,
        output wr_en, wr_addr, rd_buf, rd_buf_valid, rd_ack,
               frame_done, frame_error, capturing, frame_count, error_count
    );
endinterface

// File: rtl/camera_frame_sequencer.sv
// camera_frame_sequencer: triple-buffered frame capture; writer never touches the newest or the held buffer
module camera_frame_sequencer #(
    parameter int FRAME_PIXELS = 3542000,
    parameter int BUF_STRIDE   = 24'h400000
) (
    input logic pclk,
    input logic reset,
    camera_frame_sequencer_if.slave bus
);
    typedef enum logic {IDLE, CAPTURE} state_t;
    localparam logic [23:0] FP = 24'(FRAME_PIXELS);
    state_t      state, state_n;
    logic [23:0] cnt;
    logic        ovf, below, close, good, open, acq;
    logic [1:0]  newest, held, wr_buf, newest_n, held_n, free;
    logic        newest_valid, held_valid, nv_n, hv_n;
    logic        done_q, err_q, ack_q;
    logic [15:0] fc;
    logic [7:0]  ec;
    assign below    = cnt < FP;
    assign close    = state == CAPTURE && bus.sof;
    assign good     = cnt == FP && !ovf;
    assign open     = bus.sof && bus.enable;
    assign acq      = bus.rd_acquire && newest_valid;
    // acquire takes the pre-close newest; the closing frame becomes newest after
    assign newest_n = (close && good) ? wr_buf : newest;
    assign nv_n     = newest_valid || (close && good);
    assign held_n   = acq ? newest : held;
    assign hv_n     = acq || (held_valid && !bus.rd_release);
    always_comb begin
        free = 2'd0;
        for (int i = 2; i >= 0; i--)
            if (!(nv_n && newest_n == 2'(i)) && !(hv_n && held_n == 2'(i))) free = 2'(i);
    end
    always_comb state_n = open ? CAPTURE : close ? IDLE : state;
    always_ff @(posedge pclk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            ovf          <= 1'b0;
            newest       <= 2'd0;
            newest_valid <= 1'b0;
            held         <= 2'd0;
            held_valid   <= 1'b0;
            wr_buf       <= 2'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ack_q        <= 1'b0;
            fc           <= '0;
            ec           <= '0;
        end else begin
            state        <= state_n;
            cnt          <= bus.sof ? '0 : (state == CAPTURE && bus.pixel_valid && below) ? cnt + 24'd1 : cnt;
            ovf          <= bus.sof ? 1'b0 : ovf || (bus.pixel_valid && (state == IDLE || !below));
            newest       <= newest_n;
            newest_valid <= nv_n;
            held         <= held_n;
            held_valid   <= hv_n;
            wr_buf       <= open ? free : wr_buf;
            done_q       <= close && good;
            err_q        <= close && !good;
            ack_q        <= bus.rd_acquire;
            fc           <= fc + 16'(close && good);
            ec           <= (close && !good && ec != 8'hff) ? ec + 8'd1 : ec;
        end
    end
    always_comb begin
        bus.capturing = state == CAPTURE;
        bus.wr_en     = state == CAPTURE && bus.pixel_valid && below && !bus.sof && !reset;
        bus.wr_addr   = 26'(wr_buf) * 26'(BUF_STRIDE) + 26'(cnt);
    end
    assign bus.rd_buf       = held;
    assign bus.rd_buf_valid = held_valid;
    assign bus.rd_ack       = ack_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_error  = err_q;
    assign bus.frame_count  = fc;
    assign bus.error_count  = ec;
endmodule

// File: tb/tb_camera_frame_sequencer.sv
// tb_camera_frame_sequencer: table-driven vectors plus hand sequences for acquire/close races, enable drop and reset
module tb_camera_frame_sequencer;
    // in = {reset, enable, sof, pixel_valid, rd_acquire, rd_release}
    // f  = {wr_en, rd_buf_valid, rd_ack, frame_done, frame_error, capturing}
    typedef struct {
        int          rep;
        logic [5:0]  in;
        logic [5:0]  f;
        logic [25:0] addr;
        int          step;
        logic [1:0]  rb;
        logic [15:0] fc;
        logic [7:0]  ec;
    } vec_t;
    logic pclk = 1'b0;
    logic reset;
    int   n = 0;
    int   bad = 0;
    vec_t tbl[24];
    camera_frame_sequencer_if b();
    camera_frame_sequencer #(.FRAME_PIXELS(16)) dut (.pclk(pclk), .reset(reset), .bus(b));
    always #5 pclk = ~pclk;
    task automatic cyc(input logic [5:0] i);
        @(posedge pclk);
        #1;
        {reset, b.enable, b.sof, b.pixel_valid, b.rd_acquire, b.rd_release} = i;
        @(negedge pclk);
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [5:0] flags();
        return {b.wr_en, b.rd_buf_valid, b.rd_ack, b.frame_done, b.frame_error, b.capturing};
    endfunction
    task automatic chkv(input string nm, input logic [5:0] f, input logic [15:0] fc, input logic [7:0] ec);
        chk({nm, " flags"}, 32'(flags()), 32'(f));
        chk({nm, " frame_count"}, 32'(b.frame_count), 32'(fc));
        chk({nm, " error_count"}, 32'(b.error_count), 32'(ec));
    endtask
    initial begin
        tbl = '{
            '{1,  6'b100000, 6'b000000, 26'h0,      0, 2'd0, 16'd0, 8'd0},
            '{1,  6'b011000, 6'b000000, 26'h0,      0, 2'd0, 16'd0, 8'd0},
            '{16, 6'b010100, 6'b100001, 26'h0,      1, 2'd0, 16'd0, 8'd0},
            '{1,  6'b011000, 6'b000001, 26'h0,      0, 2'd0, 16'd0, 8'd0},
            '{1,  6'b010100, 6'b100101, 26'h400000, 0, 2'd0, 16'd1, 8'd0},
            '{1,  6'b010010, 6'b000001, 26'h0,      0, 2'd0, 16'd1, 8'd0},
            '{1,  6'b010100, 6'b111001, 26'h400001, 0, 2'd0, 16'd1, 8'd0},
            '{14, 6'b010100, 6'b110001, 26'h400002, 1, 2'd0, 16'd1, 8'd0},
            '{1,  6'b011000, 6'b010001, 26'h0,      0, 2'd0, 16'd1, 8'd0},
            '{1,  6'b010100, 6'b110101, 26'h800000, 0, 2'd0, 16'd2, 8'd0},
            '{15, 6'b010100, 6'b110001, 26'h800001, 1, 2'd0, 16'd2, 8'd0},
            '{1,  6'b011000, 6'b010001, 26'h0,      0, 2'd0, 16'd2, 8'd0},
            '{1,  6'b010100, 6'b110101, 26'h400000, 0, 2'd0, 16'd3, 8'd0},
            '{15, 6'b010100, 6'b110001, 26'h400001, 1, 2'd0, 16'd3, 8'd0},
            '{1,  6'b010001, 6'b010001, 26'h0,      0, 2'd0, 16'd3, 8'd0},
            '{1,  6'b011000, 6'b000001, 26'h0,      0, 2'd0, 16'd3, 8'd0},
            '{1,  6'b010100, 6'b100101, 26'h0,      0, 2'd0, 16'd4, 8'd0},
            '{15, 6'b010100, 6'b100001, 26'h1,      1, 2'd0, 16'd4, 8'd0},
            '{2,  6'b010100, 6'b000001, 26'h0,      0, 2'd0, 16'd4, 8'd0},
            '{1,  6'b011000, 6'b000001, 26'h0,      0, 2'd0, 16'd4, 8'd0},
            '{1,  6'b010100, 6'b100011, 26'h0,      0, 2'd0, 16'd4, 8'd1},
            '{14, 6'b010100, 6'b100001, 26'h1,      1, 2'd0, 16'd4, 8'd1},
            '{1,  6'b011000, 6'b000001, 26'h0,      0, 2'd0, 16'd4, 8'd1},
            '{1,  6'b010100, 6'b100011, 26'h0,      0, 2'd0, 16'd4, 8'd2}
        };
        {reset, b.enable, b.sof, b.pixel_valid, b.rd_acquire, b.rd_release} = 6'b100000;
        repeat (2) @(posedge pclk);
        for (int r = 0; r < 24; r++)
            for (int k = 0; k < tbl[r].rep; k++) begin
                cyc(tbl[r].in);
                chkv($sformatf("row%0d.%0d", r, k), tbl[r].f, tbl[r].fc, tbl[r].ec);
                if (tbl[r].f[5]) chk($sformatf("row%0d.%0d wr_addr", r, k), 32'(b.wr_addr), 32'(tbl[r].addr + 26'(k * tbl[r].step)));
                if (tbl[r].f[4]) chk($sformatf("row%0d.%0d rd_buf", r, k), 32'(b.rd_buf), 32'(tbl[r].rb));
            end
        // short frame from reset: nothing becomes newest, so acquire only acks
        cyc(6'b100000);
        cyc(6'b011000);
        repeat (15) cyc(6'b010100);
        cyc(6'b011000);
        cyc(6'b010010);
        chkv("short frame error", 6'b000011, 16'd0, 8'd1);
        cyc(6'b010000);
        chkv("acquire without newest", 6'b001001, 16'd0, 8'd1);
        // acquire coinciding with good close of buf 1
        cyc(6'b100000);
        cyc(6'b011000);
        repeat (16) cyc(6'b010100);
        cyc(6'b011000);
        repeat (16) cyc(6'b010100);
        cyc(6'b011010);
        cyc(6'b010100);
        chkv("acquire at close", 6'b111101, 16'd2, 8'd0);
        chk("acquire at close rd_buf", 32'(b.rd_buf), 32'd0);
        chk("acquire at close wr_addr", 32'(b.wr_addr), 32'h800000);
        // enable dropped: frame closes short, back to IDLE, pixels ignored
        cyc(6'b001000);
        cyc(6'b000100);
        chkv("enable drop close", 6'b010010, 16'd2, 8'd1);
        cyc(6'b000100);
        chkv("idle pixel", 6'b010000, 16'd2, 8'd1);
        cyc(6'b001000);
        cyc(6'b000000);
        chkv("idle sof ignored", 6'b010000, 16'd2, 8'd1);
        repeat (300) cyc(6'b011000);
        cyc(6'b001000);
        cyc(6'b000000);
        chkv("error saturation", 6'b010010, 16'd2, 8'd255);
        // reset in the middle of a frame
        cyc(6'b100000);
        cyc(6'b011000);
        repeat (8) cyc(6'b010100);
        cyc(6'b110100);
        chk("reset cycle wr_en", 32'(b.wr_en), 32'd0);
        cyc(6'b000000);
        chkv("after reset", 6'b000000, 16'd0, 8'd0);
        chk("after reset rd_buf", 32'(b.rd_buf), 32'd0);
        cyc(6'b000000);
        chkv("no late pulse", 6'b000000, 16'd0, 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n, bad);
        $finish;
    end
endmodule

// File: doc/camera_frame_sequencer.md
CAMERA_FRAME_SEQUENCER -- requirements
Module: camera_frame_sequencer

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 3542000 (1540 lines x 2300 px), valid pixels per complete frame.
REQ-002 SHALL have parameter BUF_STRIDE, default 24'h400000, address distance between frame buffers in pixels.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named pclk and reset.
REQ-004 pclk  in  1  pixel clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 enable  in  1  capture enable; sampled at each sof.
REQ-007 sof  in  1  single-cycle start-of-frame pulse from camera receiver.
REQ-008 pixel_valid  in  1  one valid pixel this cycle.
REQ-009 rd_acquire  in  1  consumer pulse: take newest complete buffer.
REQ-010 rd_release  in  1  consumer pulse: release held buffer.
REQ-011 wr_en  out  1  write strobe to frame buffer writer.
REQ-012 wr_addr  out  26  pixel write address.
REQ-013 rd_buf  out  2  buffer index held by consumer.
REQ-014 rd_buf_valid  out  1  consumer holds a buffer.
REQ-015 rd_ack  out  1  one-cycle acknowledge of rd_acquire.
REQ-016 frame_done  out  1  one-cycle pulse: frame completed good.
REQ-017 frame_error  out  1  one-cycle pulse: frame discarded (short or long).
REQ-018 capturing  out  1  high in CAPTURE state.
REQ-019 frame_count  out  16  completed good frames, wraps.
REQ-020 error_count  out  8  discarded frames, saturates at 255.

Function
REQ-021 SHALL manage three buffers (index 0..2), base address = index x BUF_STRIDE.
REQ-022 SHALL track newest (index + newest_valid) and held (rd_buf + rd_buf_valid).
REQ-023 States: IDLE, CAPTURE.
- IDLE -> CAPTURE on sof & enable.
- CAPTURE -> CAPTURE on sof & enable (frame closes, next opens same cycle).
- CAPTURE -> IDLE on sof & !enable (frame closes).
- No other transitions.
REQ-024 On entering or re-entering CAPTURE, SHALL select wr_buf = lowest index not equal to newest (if newest_valid) and not equal to held (if rd_buf_valid), using values after this cycle's updates.
REQ-025 SHALL reset 24-bit pixel counter to 0 at every sof; increment on pixel_valid while in CAPTURE and counter < FRAME_PIXELS.
REQ-026 wr_en SHALL be combinational: CAPTURE & pixel_valid & counter < FRAME_PIXELS & !sof; wr_addr = wr_buf x BUF_STRIDE + counter; zero latency.
REQ-027 pixel_valid in IDLE, or with counter = FRAME_PIXELS, SHALL write nothing and set a sticky overflow flag, cleared at sof.
REQ-028 Frame close at sof in CAPTURE:
- good = counter == FRAME_PIXELS and no overflow.
- good: newest <= wr_buf, newest_valid <= 1, frame_done pulse, frame_count + 1.
- else: frame_error pulse, error_count + 1 (saturating), newest unchanged.
- Pulses SHALL be registered, one cycle after the sof.
REQ-029 rd_acquire:
- newest_valid: rd_buf <= newest, rd_buf_valid <= 1; any previously held buffer is released in the same cycle.
- !newest_valid: no state change.
- Either case: rd_ack pulses next cycle.
REQ-030 rd_release SHALL clear rd_buf_valid; if rd_acquire and rd_release coincide, acquire wins.
REQ-031 If rd_acquire coincides with a good frame close, consumer SHALL receive the pre-close newest; the new write buffer SHALL avoid both that buffer and the just-closed buffer.
REQ-032 Writer SHALL never write the held buffer or the newest valid buffer.
REQ-033 sof with enable low in IDLE SHALL be ignored.

Reset
REQ-034 On reset SHALL set: state IDLE, counter 0, overflow 0, newest_valid 0, newest 0, rd_buf 0, rd_buf_valid 0, wr_buf 0, frame_count 0, error_count 0, all pulse outputs 0.
REQ-035 Reset mid-frame SHALL abandon the frame with no frame_done/frame_error pulse; wr_en low the same cycle reset is high.

Verification
REQ-036 FRAME_PIXELS=16; enable=1; sof, 16 pixel_valid, sof -> wr_addr 0..15 on buf 0; frame_done one cycle after second sof; newest=0; next wr_buf=1.
REQ-037 FRAME_PIXELS=16; 15 pixels then sof -> frame_error pulse, error_count=1, newest_valid stays 0; 18 pixels -> wr_en for 16 only, frame_error at sof.
REQ-038 Good frame into buf 0, rd_acquire -> rd_buf=0, rd_ack next cycle; two more good frames -> writer alternates bufs 1,2, never 0; rd_release -> buf 0 reusable.
REQ-039 rd_acquire in same cycle as good-close sof of buf 1 (newest=0) -> rd_buf=0, newest=1, next wr_buf=2.
REQ-040 enable dropped before a sof -> frame closes, state IDLE, capturing=0, later pixels produce no wr_en; 300 error frames -> error_count=255.
REQ-041 reset asserted at pixel 8 of a frame -> all outputs at reset values next cycle, no frame_done/frame_error pulse.
